snn_top: RTL and testbench

- Self-contained single-layer spiking-neural-network accelerator core (top of the neural accelerator).
- On a start pulse, it computes each output neuron's membrane sum sequentially. Each sum is the weighted sum of a fixed binary input-spike vector, using an internal constant weight ROM.
- Each sum is thresholded into an output spike, and the block then pulses done.
- Internal debug-visible registers: state, neuron_idx, input_idx, accumulator. Benches probe these hierarchically, so they must exist with exactly these names.

---
 rtl/snn_top.sv | 134 +++++++++++++
 tb/tb_snn_top.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/snn_top.sv
// ---------------------------------------------------------------------------
// snn_top - single-layer spiking neural network core.
//
// On an accepted start pulse the core evaluates every output neuron in turn:
// the membrane accumulator is cleared, the weights of all active input
// spikes are summed one input per cycle, and the signed sum is compared
// against the firing threshold to produce that neuron's output spike.
// After the last neuron a one-cycle done pulse is issued.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-low reset
//   start  - begin a layer evaluation (only looked at while idle)
//   done   - one-cycle completion pulse
//   spikes - output spike vector, bit n = neuron n; valid from done until
//            the next accepted start
// ---------------------------------------------------------------------------
module snn_top #(
    parameter int                    NUM_INPUTS   = 8,
    parameter int                    NUM_NEURONS  = 4,
    parameter int                    WEIGHT_W     = 8,
    parameter int                    ACC_W        = 16,
    parameter int                    THRESHOLD    = 40,
    parameter logic [NUM_INPUTS-1:0] INPUT_SPIKES = 8'b1011_0101
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   done,
    output logic [NUM_NEURONS-1:0] spikes
);

    localparam int IN_W = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;
    localparam int NN_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    localparam logic [IN_W-1:0] LAST_INPUT  = IN_W'(NUM_INPUTS - 1);
    localparam logic [NN_W-1:0] LAST_NEURON = NN_W'(NUM_NEURONS - 1);

    localparam logic signed [ACC_W-1:0] THR = ACC_W'(THRESHOLD);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] ACCUM = 3'd2;
    localparam logic [2:0] FIRE  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]               state;
    logic [NN_W-1:0]          neuron_idx;
    logic [IN_W-1:0]          input_idx;
    logic signed [ACC_W-1:0]  accumulator;

    // Constant weight table: w[n][i] = 4*(i - n), truncated to WEIGHT_W.
    function automatic logic signed [WEIGHT_W-1:0] rom_weight(
        input logic [NN_W-1:0] n,
        input logic [IN_W-1:0] i
    );
        int v;
        v = 4 * (int'(i) - int'(n));
        return v[WEIGHT_W-1:0];
    endfunction

    // Sign-extend the weight and add; the sum wraps modulo 2^ACC_W.
    function automatic logic signed [ACC_W-1:0] acc_add(
        input logic signed [ACC_W-1:0]    acc,
        input logic signed [WEIGHT_W-1:0] w
    );
        logic signed [ACC_W-1:0] w_ext;
        w_ext = {{(ACC_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
        return acc + w_ext;
    endfunction

    logic signed [WEIGHT_W-1:0] cur_weight;
    logic                       cur_spike;

    always_comb begin
        cur_weight = rom_weight(neuron_idx, input_idx);
        cur_spike  = INPUT_SPIKES[input_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            neuron_idx  <= '0;
            input_idx   <= '0;
            accumulator <= '0;
            spikes      <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neuron_idx <= '0;
                        spikes     <= '0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    accumulator <= '0;
                    input_idx   <= '0;
                    state       <= ACCUM;
                end
                ACCUM: begin
                    if (cur_spike) begin
                        accumulator <= acc_add(accumulator, cur_weight);
                    end
                    if (input_idx == LAST_INPUT) begin
                        state <= FIRE;
                    end else begin
                        input_idx <= input_idx + 1'b1;
                    end
                end
                FIRE: begin
                    spikes[neuron_idx] <= (accumulator >= THR);
                    if (neuron_idx == LAST_NEURON) begin
                        // done is registered so it is high exactly while in DONE
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        neuron_idx <= neuron_idx + 1'b1;
                        state      <= LOAD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_top.sv
// ---------------------------------------------------------------------------
// tb_snn_top - directed bench for snn_top.
//
// Three instances share clock, reset and start: the default core plus two
// copies with THRESHOLD overridden to 52 and 53. Expected values are the
// hand-computed membrane sums 72, 52, 32, 12 for neurons 0..3.
// ---------------------------------------------------------------------------
module tb_snn_top;

    logic       clk;
    logic       rst;
    logic       start;
    logic       done;
    logic [3:0] spikes;
    logic       done52;
    logic [3:0] spikes52;
    logic       done53;
    logic [3:0] spikes53;

    int total;
    int bad;

    // Hand-computed final membrane sums for neurons 0..3.
    int acc_exp [4] = '{72, 52, 32, 12};

    snn_top dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .done   (done),
        .spikes (spikes)
    );

    snn_top #(.THRESHOLD(52)) dut52 (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .done   (done52),
        .spikes (spikes52)
    );

    snn_top #(.THRESHOLD(53)) dut53 (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .done   (done53),
        .spikes (spikes53)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full evaluation. If glitch > 0, start is pulsed again so that it is
    // high at edge E0+glitch. Samples are taken 1 ns after each edge.
    task automatic run(input int glitch);
        int r;
        logic [2:0] st_exp;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = (glitch == 1);
        for (int t = 0; t <= 41; t++) begin
            r = t % 10;
            if (t == 40)       st_exp = 3'd4;
            else if (t > 40)   st_exp = 3'd0;
            else if (r == 0)   st_exp = 3'd1;
            else if (r == 9)   st_exp = 3'd3;
            else               st_exp = 3'd2;
            check($sformatf("state t=%0d", t), 32'(dut.state), 32'(st_exp));
            check($sformatf("done t=%0d", t), 32'(done), (t == 40) ? 32'd1 : 32'd0);
            if (t < 40)
                check($sformatf("neuron_idx t=%0d", t), 32'(dut.neuron_idx), 32'(t / 10));
            if (t < 40 && r >= 1 && r <= 8)
                check($sformatf("input_idx t=%0d", t), 32'(dut.input_idx), 32'(r - 1));
            if (t < 40 && r == 9)
                check($sformatf("acc fire n=%0d", t / 10), 32'(dut.accumulator), 32'(acc_exp[t / 10]));
            if (t >= 40) begin
                check($sformatf("spikes t=%0d", t), 32'(spikes), 32'd3);
                check($sformatf("spikes thr52 t=%0d", t), 32'(spikes52), 32'd3);
                check($sformatf("spikes thr53 t=%0d", t), 32'(spikes53), 32'd1);
            end
            if (t < 41) begin
                @(posedge clk);
                #1;
                start = (glitch > 0) && (t + 2 == glitch);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int dones;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        start = 1'b0;

        // Reset held for 20 ns
        #12;
        check("rst state", 32'(dut.state), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst spikes", 32'(spikes), 32'd0);
        check("rst acc", 32'(dut.accumulator), 32'd0);
        check("rst neuron_idx", 32'(dut.neuron_idx), 32'd0);
        check("rst input_idx", 32'(dut.input_idx), 32'd0);
        #8;
        rst = 1'b1;

        // Idle with no start
        repeat (5) @(posedge clk);
        #1;
        check("idle state", 32'(dut.state), 32'd0);
        check("idle done", 32'(done), 32'd0);
        check("idle spikes", 32'(spikes), 32'd0);
        check("idle acc", 32'(dut.accumulator), 32'd0);

        // Plain run with a one-cycle start
        run(0);

        // Run with start re-pulsed while in ACCUM (edge E0+3)
        run(3);

        // Reset mid-ACCUM of neuron 1, after neuron 0 has already fired
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("pre-abort state", 32'(dut.state), 32'd2);
        check("pre-abort spikes", 32'(spikes), 32'd1);
        rst = 1'b0;
        #2;
        check("abort state", 32'(dut.state), 32'd0);
        check("abort spikes", 32'(spikes), 32'd0);
        check("abort acc", 32'(dut.accumulator), 32'd0);
        check("abort done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        dones = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("abort no done", 32'(dones), 32'd0);
        check("abort idle state", 32'(dut.state), 32'd0);
        check("abort idle spikes", 32'(spikes), 32'd0);

        // Fresh run after the aborted one
        run(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
